// File: rtl/counter_seq.sv
// counter_seq: loadable up/down run counter with pause, abort and terminal-count detection.
//
// A run is started from IDLE with a direction, an initial count and a terminal count, all
// latched on the accepting edge. The counter steps once per RUN cycle until the updated count
// equals the latched target, spends one cycle in DONE, and then either returns to IDLE or,
// when the build macro COUNTER_SEQ_AUTORELOAD_EN is defined, reloads the initial count and
// runs again until aborted.
//
// Output timing, all outputs registered:
//   cnt     - the count itself.
//   busy    - high while the FSM sits in RUN or HOLD.
//   done    - one-cycle pulse in the cycle after DONE, i.e. one cycle after cnt first shows
//             the target value.
//   aborted - one-cycle pulse in the cycle after an abort was taken.
//   wrapped - sticky wrap-around flag, cleared only by an accepted start.

module counter_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] target,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrapped
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] AllZero = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             wrapped_q, wrapped_d;

  logic [WIDTH-1:0] cnt_step;
  logic             step_wraps;
  logic             start_ok;

  // Next count in the latched direction and whether that step crosses the wrap boundary.
  always_comb begin
    cnt_step   = cnt_q;
    step_wraps = 1'b0;
    if (dir_q) begin
      cnt_step   = cnt_q + One;
      step_wraps = (cnt_q == AllOnes);
    end else begin
      cnt_step   = cnt_q - One;
      step_wraps = (cnt_q == AllZero);
    end
  end

  // A start is taken only in IDLE and never in the cycle that shows the done pulse.
  always_comb begin
    start_ok = (state_q == StIdle) && start && !done_q;
  end

  // Next-state and next-output logic; every target gets its hold value first.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    load_d    = load_q;
    target_d  = target_q;
    wrapped_d = wrapped_q;
    aborted_d = 1'b0;
    // done trails the DONE state by one cycle so it follows the first visible target count.
    done_d    = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          dir_d     = dir;
          load_d    = load_val;
          target_d  = target;
          cnt_d     = load_val;
          wrapped_d = 1'b0;
          state_d   = (load_val == target) ? StDone : StRun;
        end
      end

      StRun: begin
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (pause) begin
          // The pausing edge itself does not count.
          state_d = StHold;
        end else begin
          cnt_d = cnt_step;
          if (step_wraps) begin
            wrapped_d = 1'b1;
          end
          if (cnt_step == target_q) begin
            state_d = StDone;
          end
        end
      end

      StHold: begin
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (!pause) begin
          // Resume without stepping; counting restarts on the following edge.
          state_d = StRun;
        end
      end

      StDone: begin
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else begin
          // Reload for another pass; wrapped stays sticky across passes.
          cnt_d   = load_q;
          state_d = (load_q == target_q) ? StDone : StRun;
        end
`else
        state_d = StIdle;
`endif
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StRun) || (state_d == StHold);
  end

  // State and output registers; reset discards any run without emitting pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= AllZero;
      dir_q     <= 1'b0;
      load_q    <= AllZero;
      target_q  <= AllZero;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      load_q    <= load_d;
      target_q  <= target_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Drive the ports straight from the registers.
  always_comb begin
    cnt     = cnt_q;
    busy    = busy_q;
    done    = done_q;
    aborted = aborted_q;
    wrapped = wrapped_q;
  end

endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: directed self-checking bench for counter_seq (WIDTH = 8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.

module tb_counter_seq;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         dir;
  logic [W-1:0] load_val;
  logic [W-1:0] target;
  logic         pause;
  logic         abort;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic         aborted;
  logic         wrapped;

  int checks;
  int failures;

  counter_seq #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dir     (dir),
    .load_val(load_val),
    .target  (target),
    .pause   (pause),
    .abort   (abort),
    .cnt     (cnt),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .wrapped (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic d, input logic [W-1:0] lv, input logic [W-1:0] tg);
    start    = 1'b1;
    dir      = d;
    load_val = lv;
    target   = tg;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0; dir = 1'b0; load_val = '0; target = '0; pause = 1'b0; abort = 1'b0;
    #3 rst_n = 1'b0;
    tick();
    checks++;
    if ({cnt, busy, done, aborted, wrapped} !== {8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL reset_state: got cnt=%h b=%b d=%b a=%b w=%b want all zero",
               cnt, busy, done, aborted, wrapped);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_up_run();
    begin_run(1'b1, 8'h10, 8'h14);
    checks++;
    if (cnt !== 8'h10 || busy !== 1'b1) begin
      failures++;
      $display("FAIL up_load: got cnt=%h busy=%b want 10/1", cnt, busy);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (cnt !== 8'(8'h10 + i) || done !== 1'b0) begin
        failures++;
        $display("FAIL up_step%0d: got cnt=%h done=%b want %h/0", i, cnt, done, 8'(8'h10 + i));
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || cnt !== 8'h14 || busy !== 1'b0 || wrapped !== 1'b0) begin
      failures++;
      $display("FAIL up_done: got d=%b cnt=%h b=%b w=%b want 1/14/0/0", done, cnt, busy, wrapped);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL up_done_width: got done=%b want 0", done);
    end
  endtask

  task automatic test_down_wrap();
    logic [W-1:0] exp_cnt [4];
    logic         exp_wrp [4];
    exp_cnt[0] = 8'h01; exp_cnt[1] = 8'h00; exp_cnt[2] = 8'hFF; exp_cnt[3] = 8'hFE;
    exp_wrp[0] = 1'b0;  exp_wrp[1] = 1'b0;  exp_wrp[2] = 1'b1;  exp_wrp[3] = 1'b1;
    begin_run(1'b0, 8'h02, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (cnt !== exp_cnt[i] || wrapped !== exp_wrp[i] || done !== 1'b0) begin
        failures++;
        $display("FAIL down_step%0d: got cnt=%h w=%b d=%b want %h/%b/0",
                 i, cnt, wrapped, done, exp_cnt[i], exp_wrp[i]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || cnt !== 8'hFE || wrapped !== 1'b1) begin
      failures++;
      $display("FAIL down_done: got d=%b cnt=%h w=%b want 1/fe/1", done, cnt, wrapped);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL down_single_done: got done=%b want 0", done);
    end
  endtask

  task automatic test_pause_abort();
    begin_run(1'b1, 8'h00, 8'h80);
    checks++;
    if (wrapped !== 1'b0 || cnt !== 8'h00) begin
      failures++;
      $display("FAIL start_clears_wrap: got w=%b cnt=%h want 0/00", wrapped, cnt);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (cnt !== 8'h05) begin
      failures++;
      $display("FAIL pa_count: got cnt=%h want 05", cnt);
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cnt !== 8'h05 || busy !== 1'b1) begin
        failures++;
        $display("FAIL pa_hold%0d: got cnt=%h busy=%b want 05/1", i, cnt, busy);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    pause = 1'b0;
    checks++;
    if (aborted !== 1'b1 || cnt !== 8'h05 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL pa_abort: got a=%b cnt=%h b=%b d=%b want 1/05/0/0",
               aborted, cnt, busy, done);
    end
    tick();
    checks++;
    if (aborted !== 1'b0 || done !== 1'b0 || cnt !== 8'h05) begin
      failures++;
      $display("FAIL pa_after: got a=%b d=%b cnt=%h want 0/0/05", aborted, done, cnt);
    end
  endtask

  task automatic test_degenerate();
    begin_run(1'b1, 8'h33, 8'h33);
    checks++;
    if (cnt !== 8'h33 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL degen_load: got cnt=%h b=%b d=%b want 33/0/0", cnt, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || cnt !== 8'h33) begin
      failures++;
      $display("FAIL degen_done: got d=%b cnt=%h want 1/33", done, cnt);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    begin_run(1'b1, 8'h20, 8'h24);
    // Competing start held high during the run must not relatch anything.
    start = 1'b1; dir = 1'b0; load_val = 8'h90; target = 8'h91;
    tick();
    tick();
    start = 1'b0;
    checks++;
    if (cnt !== 8'h22) begin
      failures++;
      $display("FAIL ign_no_relatch: got cnt=%h want 22", cnt);
    end
    pause = 1'b1;
    tick();
    pause = 1'b0;
    tick();
    checks++;
    if (cnt !== 8'h22 || busy !== 1'b1) begin
      failures++;
      $display("FAIL resume_no_step: got cnt=%h b=%b want 22/1", cnt, busy);
    end
    tick();
    tick();
    checks++;
    if (cnt !== 8'h24 || done !== 1'b0) begin
      failures++;
      $display("FAIL ign_target: got cnt=%h d=%b want 24/0", cnt, done);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL ign_done: got done=%b want 1", done);
    end
    // Start presented in the done cycle is dropped.
    start = 1'b1; dir = 1'b1; load_val = 8'h50; target = 8'h60;
    tick();
    start = 1'b0;
    checks++;
    if (cnt !== 8'h24 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle_start: got cnt=%h b=%b want 24/0", cnt, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    begin_run(1'b1, 8'h00, 8'hF0);
    for (int i = 0; i < 64; i++) tick();
    checks++;
    if (cnt !== 8'h40) begin
      failures++;
      $display("FAIL mid_pre: got cnt=%h want 40", cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt, busy, done, aborted, wrapped} !== {8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL mid_async: got cnt=%h b=%b d=%b a=%b w=%b want all zero",
               cnt, busy, done, aborted, wrapped);
    end
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (done !== 1'b0 || aborted !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_pulse: got d=%b a=%b want 0/0", done, aborted);
    end
    begin_run(1'b1, 8'h07, 8'h70);
    checks++;
    if (cnt !== 8'h07 || busy !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_start: got cnt=%h b=%b want 07/1", cnt, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_autoreload();
    int n_done;
    n_done = 0;
    begin_run(1'b1, 8'h00, 8'h03);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done === 1'b1) n_done++;
      checks++;
      if (done !== ((i % 4) == 0)) begin
        failures++;
        $display("FAIL ar_done_t%0d: got done=%b want %b", i, done, (i % 4) == 0);
      end
    end
    checks++;
    if (n_done != 3) begin
      failures++;
      $display("FAIL ar_count: got %0d pulses want 3", n_done);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ar_abort: got a=%b b=%b want 1/0", aborted, busy);
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
`ifdef COUNTER_SEQ_AUTORELOAD_EN
    test_pause_abort();
    test_reset_mid_run();
    test_autoreload();
`else
    test_up_run();
    test_down_wrap();
    test_pause_abort();
    test_degenerate();
    test_ignored_start();
    test_reset_mid_run();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
